// File: rtl/e_mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and the result-class tag used between e_mdu and e_mdu_calc.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    mdop_nope  = 4'd0,
    mdop_mult  = 4'd1,
    mdop_multu = 4'd2,
    mdop_div   = 4'd3,
    mdop_divu  = 4'd4,
    mdop_mfhi  = 4'd5,
    mdop_mflo  = 4'd6,
    mdop_mthi  = 4'd7,
    mdop_mtlo  = 4'd8,
    mdop_madd  = 4'd9,
    mdop_maddu = 4'd10,
    mdop_msub  = 4'd11,
    mdop_msubu = 4'd12
  } mdop_e;

  typedef enum logic [1:0] {
    cls_none = 2'd0,
    cls_mul  = 2'd1,
    cls_div  = 2'd2
  } mdcls_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic int cnt_bits(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational MDU datapath: pending {hi,lo} for mult/div (and the
// accumulate ops when MDU_MADD_EN is defined) plus the latency class.
module e_mdu_calc
  import e_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       mdOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output mdcls_e           cls,
  output logic [WIDTH-1:0] pend_hi,
  output logic [WIDTH-1:0] pend_lo
);

  localparam int W2 = 2 * WIDTH;

  logic             sgn;
  logic [W2-1:0]    ext_a, ext_b, prod;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
`ifdef MDU_MADD_EN
  logic [W2-1:0]    acc;
`endif

  always_comb begin
    sgn = 1'b0;
    cls = cls_none;
    case (mdOp)
      mdop_mult:  begin sgn = 1'b1; cls = cls_mul; end
      mdop_multu: cls = cls_mul;
      mdop_div:   begin sgn = 1'b1; cls = cls_div; end
      mdop_divu:  cls = cls_div;
`ifdef MDU_MADD_EN
      mdop_madd, mdop_msub:   begin sgn = 1'b1; cls = cls_mul; end
      mdop_maddu, mdop_msubu: cls = cls_mul;
`endif
      default: ;
    endcase
  end

  // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of an unsigned
  // multiply equal to the signed product.
  assign ext_a = sgn ? {{WIDTH{srcA[WIDTH-1]}}, srcA} : {{WIDTH{1'b0}}, srcA};
  assign ext_b = sgn ? {{WIDTH{srcB[WIDTH-1]}}, srcB} : {{WIDTH{1'b0}}, srcB};
  assign prod  = ext_a * ext_b;

  // Magnitude divide then re-sign: truncates toward zero, remainder follows
  // the dividend, and MIN/-1 wraps back to MIN with zero remainder.
  assign a_neg  = sgn & srcA[WIDTH-1];
  assign b_neg  = sgn & srcB[WIDTH-1];
  assign a_mag  = a_neg ? -srcA : srcA;
  assign b_mag  = b_neg ? -srcB : srcB;
  assign b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem    = a_neg ? -r_mag : r_mag;

`ifdef MDU_MADD_EN
  assign acc = ((mdOp == mdop_msub) || (mdOp == mdop_msubu)) ? ({hi, lo} - prod)
                                                             : ({hi, lo} + prod);
`endif

  always_comb begin
    {pend_hi, pend_lo} = prod;
    if (cls == cls_div) begin
      if (srcB == '0) {pend_hi, pend_lo} = {hi, lo};
      else            {pend_hi, pend_lo} = {rem, quo};
    end
`ifdef MDU_MADD_EN
    else if (mdOp >= mdop_madd && mdOp <= mdop_msubu) begin
      {pend_hi, pend_lo} = acc;
    end
`endif
  end

endmodule

// File: rtl/e_mdu.sv
// EX-stage multiply/divide unit: HI/LO owner with fixed-latency busy window.
// Build with MDU_MADD_EN to add madd/maddu/msub/msubu.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic [WIDTH-1:0] hiloOut
);

  localparam int CW = cnt_bits(MULT_CYCLES, DIV_CYCLES);

  logic [WIDTH-1:0] hi, lo, pend_hi, pend_lo, calc_hi, calc_lo;
  logic [CW-1:0]    cnt;
  mdcls_e           cls;

  e_mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .mdOp    (mdOp),
    .srcA    (srcA),
    .srcB    (srcB),
    .hi      (hi),
    .lo      (lo),
    .cls     (cls),
    .pend_hi (calc_hi),
    .pend_lo (calc_lo)
  );

  assign busy = (cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      cnt     <= '0;
    end else if (busy) begin
      // start is dropped while busy; the hazard unit holds the instruction.
      if (cnt == CW'(1)) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
      cnt <= cnt - CW'(1);
    end else if (start) begin
      case (cls)
        cls_mul: begin
          pend_hi <= calc_hi;
          pend_lo <= calc_lo;
          cnt     <= CW'(MULT_CYCLES);
        end
        cls_div: begin
          pend_hi <= calc_hi;
          pend_lo <= calc_lo;
          cnt     <= CW'(DIV_CYCLES);
        end
        default: begin
          if (mdOp == mdop_mthi) hi <= srcA;
          if (mdOp == mdop_mtlo) lo <= srcA;
        end
      endcase
    end
  end

  always_comb begin
    hiloOut = '0;
    if (mdOp == mdop_mfhi)      hiloOut = hi;
    else if (mdOp == mdop_mflo) hiloOut = lo;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: expected HI/LO and busy length are queued when an
// op is issued and popped when busy falls.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  mdOp;
  logic [31:0] srcA, srcB;
  logic        busy;
  logic [31:0] hiloOut;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdOp    (mdOp),
    .srcA    (srcA),
    .srcB    (srcB),
    .busy    (busy),
    .hiloOut (hiloOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(output logic [63:0] v);
    mdOp = 4'd5;
    #1 v[63:32] = hiloOut;
    mdOp = 4'd6;
    #1 v[31:0] = hiloOut;
    mdOp = 4'd0;
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; mdOp = op; srcA = a; srcB = b;
    @(negedge clk);
    start = 1'b0; mdOp = 4'd0;
  endtask

  task automatic post(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp, input int lat);
    issue(op, a, b);
    exp_q.push_back(exp);
    lat_q.push_back(lat);
  endtask

  task automatic complete(input string tag);
    int n;
    logic [63:0] v, e;
    int l;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() == 0) begin
      chk({tag, " queue"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      chk({tag, " busy_cycles"}, 64'(n), 64'(l));
      read_hilo(v);
      chk({tag, " hilo"}, v, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] v;
    logic [63:0] m;
    reset = 1'b1; start = 1'b0; mdOp = 4'd0; srcA = '0; srcB = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    read_hilo(v);
    chk("reset hilo", v, 64'd0);
    reset = 1'b0;

    // Reset on the second busy cycle of a mult must discard it.
    issue(4'd1, 32'd7, 32'd6);
    chk("midrst busy c1", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("midrst busy async", 64'(busy), 64'd0);
    read_hilo(v);
    chk("midrst hilo", v, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst later busy", 64'(busy), 64'd0);
    read_hilo(v);
    chk("midrst later hilo", v, 64'd0);

    m = 64'hFFFF_FFFF * 64'hFFFF_FFFF;
    post(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, m, 5);
    complete("multu max");
    mdOp = 4'd6;
    #1 chk("multu mflo", 64'(hiloOut), 64'h1);
    mdOp = 4'd0;

    post(4'd1, -32'sd3, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 5);
    complete("mult -3*5");

    post(4'd3, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
    complete("div -7/2");

    post(4'd4, 32'd100, 32'd7, {32'd2, 32'd14}, 10);
    complete("divu 100/7");

    post(4'd3, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD}, 10);
    complete("div 7/-2");

    post(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10);
    complete("div overflow");

    post(4'd7, 32'h11, 32'd0, {32'h11, 32'h8000_0000}, 0);
    complete("mthi");
    post(4'd8, 32'h22, 32'd0, {32'h11, 32'h22}, 0);
    complete("mtlo");

    post(4'd3, 32'h8000_0000, 32'd0, {32'h11, 32'h22}, 10);
    complete("div by zero");

    // mthi offered one cycle into the mult is ignored; one busy cycle is
    // consumed by that attempt, so four remain to be counted.
    post(4'd1, 32'd100, 32'd3, {32'd0, 32'd300}, 4);
    start = 1'b1; mdOp = 4'd7; srcA = 32'h55;
    @(negedge clk);
    start = 1'b0; mdOp = 4'd0;
    complete("mult w/ mthi while busy");

    post(4'd8, 32'hABCD, 32'd0, {32'd0, 32'hABCD}, 0);
    chk("mtlo busy", 64'(busy), 64'd0);
    complete("mtlo idle");

`ifdef MDU_MADD_EN
    post(4'd9, 32'd2, 32'd3, {32'd0, 32'hABCD + 32'd6}, 5);
`else
    post(4'd9, 32'd2, 32'd3, {32'd0, 32'hABCD}, 0);
`endif
    complete("madd");

    post(4'd0, 32'h1234, 32'h5678, exp_q.size() == 0 ? 64'd0 : 64'd0, 0);
    exp_q.pop_back();
    read_hilo(v);
    exp_q.push_back(v);
    complete("nope");

    mdOp = 4'd1;
    #1 chk("hiloOut non-mf", 64'(hiloOut), 64'd0);
    mdOp = 4'd0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
